// File: rtl/w5300_pkg.sv
// w5300_pkg: W5300 register map and bus operation encodings
package w5300_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [9:0] IR_ADDR      = 10'h002;
    localparam logic [9:0] SN_BASE      = 10'h200;
    localparam logic [9:0] SN_IR_OFS    = 10'h006;
    localparam logic [9:0] SN_SSR_OFS   = 10'h008;
    localparam logic [9:0] SN_RSR0_OFS  = 10'h028;
    localparam logic [9:0] SN_RSR2_OFS  = 10'h02A;

    // each socket owns a 0x40 window above SN_BASE
    function automatic logic [9:0] sn_reg(input int n, input logic [9:0] ofs);
        return SN_BASE + 10'(n * 64) + ofs;
    endfunction

endpackage

// File: rtl/w5300_poll_timer.sv
// w5300_poll_timer: free-running poll interval counter with reload and expiry flag
module w5300_poll_timer #(
    parameter int POLL_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic reload_i,
    output logic expired_o
);

    localparam int W = $clog2(POLL_CYCLES);
    localparam logic [W-1:0] LAST = W'(POLL_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // saturates at LAST so a poll longer than the interval still starts the next one promptly
    always_comb cnt_d = (reload_i || !en_i) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + W'(1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/w5300_status_reader.sv
// w5300_status_reader: polls W5300 IR and socket N status registers, clearing Sn_IR when set
module w5300_status_reader
    import w5300_pkg::*;
#(
    parameter int N           = 0,
    parameter int POLL_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        start,
    output logic        req,
    output logic [10:0] addr,
    output logic [15:0] wr_data,
    input  logic        op_done,
    input  logic [15:0] rd_data,
    output logic [15:0] ir,
    output logic [7:0]  sn_ir,
    output logic [7:0]  sn_ssr,
    output logic [16:0] rx_rsr,
    output logic        valid,
    output logic        busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_IR   = 3'd1;
    localparam logic [2:0] RD_SIR  = 3'd2;
    localparam logic [2:0] CLR_SIR = 3'd3;
    localparam logic [2:0] RD_SSR  = 3'd4;
    localparam logic [2:0] RD_RSR0 = 3'd5;
    localparam logic [2:0] RD_RSR2 = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    localparam logic [9:0] A_SIR  = sn_reg(N, SN_IR_OFS);
    localparam logic [9:0] A_SSR  = sn_reg(N, SN_SSR_OFS);
    localparam logic [9:0] A_RSR0 = sn_reg(N, SN_RSR0_OFS);
    localparam logic [9:0] A_RSR2 = sn_reg(N, SN_RSR2_OFS);

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_s_q;
    logic [7:0]  sir_s_q, ssr_s_q;
    logic        rsr0_s_q;
    logic        expired, go;

    assign go = start || (enable && expired);

    w5300_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en_i      (enable),
        .reload_i  (state_q == IDLE && go),
        .expired_o (expired)
    );

    assign req     = (state_q != IDLE) && (state_q != DONE);
    assign busy    = req;
    assign valid   = state_q == DONE;
    assign wr_data = (state_q == CLR_SIR) ? {8'h00, sir_s_q} : 16'h0000;

    always_comb begin
        addr = (state_q == RD_IR)   ? {OP_RD, IR_ADDR} :
               (state_q == RD_SIR)  ? {OP_RD, A_SIR}   :
               (state_q == CLR_SIR) ? {OP_WR, A_SIR}   :
               (state_q == RD_SSR)  ? {OP_RD, A_SSR}   :
               (state_q == RD_RSR0) ? {OP_RD, A_RSR0}  :
               (state_q == RD_RSR2) ? {OP_RD, A_RSR2}  : {OP_RD, 10'h000};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = RD_IR;
            RD_IR:   if (op_done) state_d = RD_SIR;
            RD_SIR:  if (op_done) state_d = (rd_data[7:0] != 8'h00) ? CLR_SIR : RD_SSR;
            CLR_SIR: if (op_done) state_d = RD_SSR;
            RD_SSR:  if (op_done) state_d = RD_RSR0;
            RD_RSR0: if (op_done) state_d = RD_RSR2;
            RD_RSR2: if (op_done) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // outputs load together on the final read so they are coherent while valid is high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ir_s_q   <= '0;
            sir_s_q  <= '0;
            ssr_s_q  <= '0;
            rsr0_s_q <= 1'b0;
            ir       <= '0;
            sn_ir    <= '0;
            sn_ssr   <= '0;
            rx_rsr   <= '0;
        end else begin
            state_q <= state_d;
            if (op_done) begin
                case (state_q)
                    RD_IR:   ir_s_q   <= rd_data;
                    RD_SIR:  sir_s_q  <= rd_data[7:0];
                    RD_SSR:  ssr_s_q  <= rd_data[7:0];
                    RD_RSR0: rsr0_s_q <= rd_data[0];
                    RD_RSR2: begin
                        ir     <= ir_s_q;
                        sn_ir  <= sir_s_q;
                        sn_ssr <= ssr_s_q;
                        rx_rsr <= {rsr0_s_q, rd_data};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
